inst_fetch: RTL
===============

# inst_fetch

Instruction fetch front end sitting between instruction memory and the `cpu` core's decode logic. It generates sequential word addresses, runs a req/ack handshake with a variable-latency instruction memory, and buffers returned words with their PCs in a small prefetch queue. It presents them to the core with a valid/ready handshake. A core redirect (taken branch/jump) flushes the queue and restarts fetch at the new PC, discarding any in-flight stale response.

## Interface

- `DEPTH`, 2: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; word aligned.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `mem_req` output 1: fetch request to instruction memory.
- `mem_addr` output 32: word address of the current request; bits [1:0] always 0.
- `mem_ack` input 1: memory completes the request this cycle; only meaningful while `mem_req`=1.
- `mem_rdata` input 32: instruction word, valid when `mem_ack`=1.
- `inst_valid` output 1: queue head holds an instruction.
- `inst_val` output 32: head instruction word.
- `inst_pc` output 32: address the head word was fetched from.
- `inst_ready` input 1: core consumes the head this cycle.
- `redirect` input 1: core requests a fetch restart.
- `redirect_pc` input 32: restart address; bits [1:0] ignored (treated as 0).

## Operation

- State register `st` ∈ {FETCH, DROP}; registers `fetch_pc`, `req_addr`, queue storage of DEPTH × {pc, word}, read/write pointers, and an occupancy count 0..DEPTH.
- The memory transfer completes on any edge where `mem_req`=1 and `mem_ack`=1. Zero-wait memories may ack in the same cycle `mem_req` rises.
- The request rule is `mem_req` = (`st`=FETCH and count<DEPTH) or `st`=DROP. Once raised, `mem_req` and `mem_addr` stay stable until the ack edge; count can only rise through an ack, so the condition cannot drop early.
- `mem_addr` = `req_addr`. In FETCH with no request pending, `req_addr` tracks `fetch_pc`.
- FETCH, on an ack without redirect:
  - push {`req_addr`, `mem_rdata`} into the queue;
  - `fetch_pc` ← `req_addr`+4 (wraps modulo 2^32);
  - `req_addr` ← the same value;
  - if room remains, the next request is issued in the following cycle, back-to-back.
- Pop: `inst_valid`=1 and `inst_ready`=1 removes the head. A push and a pop in the same cycle leave count unchanged. A push into a full queue cannot occur, because the request rule prevents it.
- Redirect, which has priority over push and pop:
  - queue flushed to count=0;
  - `fetch_pc` ← {`redirect_pc`[31:2],2'b00};
  - if `mem_req`=1 and no ack this cycle: go to DROP, and `req_addr` keeps the stale address;
  - otherwise (no request, or ack this same cycle with its data discarded): stay FETCH with `req_addr` ← new `fetch_pc`.
- DROP:
  - `mem_req` is held with the stale `req_addr`;
  - on ack, `mem_rdata` is discarded, `req_addr` ← `fetch_pc`, go to FETCH;
  - a redirect in DROP only updates `fetch_pc` and the flush; stay DROP until the ack;
  - `inst_valid`=0 throughout, since the queue is empty after the flush.
- Outputs `inst_val` and `inst_pc` are don't-care when `inst_valid`=0, but must be driven from queue storage with no X-propagation into `inst_valid`.

## Timing

- Reset values:
  - `mem_req`=0, `mem_addr`=RESET_PC, `inst_valid`=0;
  - count=0, `st`=FETCH;
  - `fetch_pc`=`req_addr`=RESET_PC.
- `mem_req` is a registered state function. It is 1 in the first cycle after `rst` deasserts, and is combinational only from `st`/count.
- Fetch latency: ack in cycle N → `inst_valid`=1 in cycle N+1. There is no bypass from memory to the core.
- Throughput: with zero-wait memory and `inst_ready` held at 1, one instruction per cycle is sustained.
- Redirect in cycle N: `inst_valid`=0 in N+1.
  - No request outstanding: `mem_req` for the new PC is at the earliest in N+1.
  - Stale request outstanding: the new request follows the cycle after the stale ack.
- `rst` mid-transfer: all state returns to reset values at that edge. A late `mem_ack` arriving while `mem_req`=0 is ignored. The memory is required to abandon the request when `mem_req` drops due to reset.

## Test plan

- **Reset and startup.** Hold `rst` 3 cycles with zero-wait memory returning `mem_rdata`=addr^32'hA5A5_0000. Expect:
  - `mem_addr` = 0, 4, 8… on consecutive cycles;
  - `inst_valid` rises in cycle 2 after release with `inst_pc`=0, `inst_val`=32'hA5A5_0000.
- **Backpressure and full queue.** `inst_ready`=0, DEPTH=2. Expect:
  - exactly 2 acks (PCs 0, 4), then `mem_req`=0;
  - raising `inst_ready` pops PC 0 then PC 4 in order, and `mem_req` re-asserts for addr 8 the cycle after the first pop.
- **Wait-state memory.** Ack 3 cycles after each request. Expect:
  - `mem_addr` stable while `mem_req`=1;
  - one queue entry per ack;
  - `inst_pc` sequence 0, 4, 8 with no duplicates.
- **Redirect during an outstanding request.** Request at addr 8 pending, `redirect`=1 with `redirect_pc`=32'h100. Expect:
  - DROP, with `mem_addr` still 8 until the ack, that data not delivered;
  - next request addr 32'h100, and the first `inst_pc` after that is 32'h100.
- **Same-cycle events and alignment.** Redirect coincident with an ack and with `inst_ready`=1, `redirect_pc`=32'h203. Expect:
  - the acked word is discarded;
  - next `mem_addr`=32'h200 the following cycle;
  - the queue is empty in the next cycle.
- **Wrap-around.** RESET_PC=32'hFFFF_FFFC. Expect the second fetch at `mem_addr`=32'h0000_0000 and `inst_pc` sequence FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch front end: sequential word fetch over a req/ack memory port,
// a DEPTH-entry prefetch queue of {pc, word}, and redirect with stale-response drop.
module inst_fetch #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_val,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_DROP  = 1'b1
   } st_t;

   st_t              st_r, st_s;
   logic [31:0]      fetch_pc_r, fetch_pc_s;
   logic [31:0]      req_addr_r, req_addr_s;
   logic [PTR_W-1:0] rd_ptr_r, rd_ptr_s;
   logic [PTR_W-1:0] wr_ptr_r, wr_ptr_s;
   logic [CNT_W-1:0] count_r, count_s;
   logic [31:0]      q_pc_r   [DEPTH];
   logic [31:0]      q_word_r [DEPTH];

   logic             req_cond_s;
   logic             ack_s;
   logic             pop_s;
   logic             push_s;
   logic [31:0]      redir_pc_s;
   logic             unused_s;

   // Request depends only on state and occupancy; reset forces it low so memory abandons it.
   always_comb begin
      req_cond_s = (st_r == ST_DROP) || (count_r < DEPTH_C);
      mem_req    = req_cond_s && !rst;
      mem_addr   = req_addr_r;
      ack_s      = mem_req && mem_ack;
      inst_valid = (count_r != {CNT_W{1'b0}});
      inst_val   = q_word_r[rd_ptr_r];
      inst_pc    = q_pc_r[rd_ptr_r];
      pop_s      = inst_valid && inst_ready;
      redir_pc_s = {redirect_pc[31:2], 2'b00};
      unused_s   = ^redirect_pc[1:0];
   end

   // Next-state logic: redirect overrides push/pop and decides whether a stale ack must be dropped.
   always_comb begin
      st_s       = st_r;
      fetch_pc_s = fetch_pc_r;
      req_addr_s = req_addr_r;
      rd_ptr_s   = rd_ptr_r;
      wr_ptr_s   = wr_ptr_r;
      count_s    = count_r;
      push_s     = 1'b0;
      if (redirect) begin
         count_s    = {CNT_W{1'b0}};
         rd_ptr_s   = {PTR_W{1'b0}};
         wr_ptr_s   = {PTR_W{1'b0}};
         fetch_pc_s = redir_pc_s;
         if (mem_req && !mem_ack) begin
            st_s       = ST_DROP;
            req_addr_s = req_addr_r;
         end else begin
            st_s       = ST_FETCH;
            req_addr_s = redir_pc_s;
         end
      end else begin
         case (st_r)
            ST_FETCH: begin
               if (ack_s) begin
                  push_s     = 1'b1;
                  wr_ptr_s   = wr_ptr_r + PTR_W'(1);
                  fetch_pc_s = req_addr_r + 32'd4;
                  req_addr_s = req_addr_r + 32'd4;
               end else if (!mem_req) begin
                  req_addr_s = fetch_pc_r;
               end else begin
                  req_addr_s = req_addr_r;
               end
               if (pop_s) begin
                  rd_ptr_s = rd_ptr_r + PTR_W'(1);
               end else begin
                  rd_ptr_s = rd_ptr_r;
               end
               case ({push_s, pop_s})
                  2'b10:   count_s = count_r + CNT_W'(1);
                  2'b01:   count_s = count_r - CNT_W'(1);
                  default: count_s = count_r;
               endcase
            end
            ST_DROP: begin
               if (ack_s) begin
                  req_addr_s = fetch_pc_r;
                  st_s       = ST_FETCH;
               end else begin
                  st_s       = ST_DROP;
               end
            end
            default: begin
               st_s = ST_FETCH;
            end
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_r       <= ST_FETCH;
         fetch_pc_r <= RESET_PC;
         req_addr_r <= RESET_PC;
         rd_ptr_r   <= {PTR_W{1'b0}};
         wr_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
      end else begin
         st_r       <= st_s;
         fetch_pc_r <= fetch_pc_s;
         req_addr_r <= req_addr_s;
         rd_ptr_r   <= rd_ptr_s;
         wr_ptr_r   <= wr_ptr_s;
         count_r    <= count_s;
      end
   end

   // Queue storage; cleared on reset so the head outputs never carry X.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_pc_r[i]   <= 32'h0000_0000;
            q_word_r[i] <= 32'h0000_0000;
         end
      end else if (push_s) begin
         q_pc_r[wr_ptr_r]   <= req_addr_r;
         q_word_r[wr_ptr_r] <= mem_rdata;
      end else begin
         q_pc_r[wr_ptr_r]   <= q_pc_r[wr_ptr_r];
         q_word_r[wr_ptr_r] <= q_word_r[wr_ptr_r];
      end
   end

endmodule
